// File: rtl/cart_loader.sv
// cart_loader: boot sequencer that streams the cartridge ROM from SPI flash into block RAM,
// then releases the core. Define CART_LOADER_HDRCHK_EN to add the header checksum check (hdr_err).
module cart_loader #(
   parameter int          ROM_BYTES  = 32768,
   parameter logic [23:0] FLASH_BASE = 24'h100000,
   parameter int          SCLK_DIV   = 2,
   parameter int          RST_HOLD   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        flash_sclk,
   output logic        flash_cs_n,
   output logic        flash_mosi,
   input  logic        flash_miso,
   input  logic [15:0] gb_addr,
   input  logic        gb_rd,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   output logic        mem_en,
   output logic        gb_rst,
   output logic        busy,
   output logic        done
`ifdef CART_LOADER_HDRCHK_EN
   ,
   output logic        hdr_err
`endif
);

   localparam int          BCW       = $clog2(ROM_BYTES) + 1;
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(ROM_BYTES - 1);
   localparam logic [BCW-1:0] BYTE_ONE  = BCW'(1);
   localparam logic [15:0] DIV_LAST  = 16'(SCLK_DIV - 1);
   localparam logic [31:0] CMD_WORD  = {8'h03, FLASH_BASE};

   typedef enum logic [2:0] {CS_SETUP, CMD, DATA, CS_HOLD, RELEASE, RUN} state_t;

   state_t         state_q, state_d;
   logic [15:0]    div_cnt_q, div_cnt_d;
   logic           sclk_q, sclk_d;
   logic           cs_n_q, cs_n_d;
   logic [31:0]    cmd_sr_q, cmd_sr_d;
   logic [6:0]     rx_sr_q, rx_sr_d;
   logic [4:0]     bit_cnt_q, bit_cnt_d;
   logic           mem_we_q, mem_we_d;
   logic [7:0]     mem_din_q, mem_din_d;
   logic [15:0]    addr_q, addr_d;
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
   logic [15:0]    hold_cnt_q, hold_cnt_d;
   logic           gb_rst_q, gb_rst_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic div_tick, last_wr, hold_done, hdr_bad;

   assign div_tick  = (div_cnt_q == DIV_LAST);
   assign last_wr   = mem_we_q && (byte_cnt_q == BYTE_LAST);
   // The reset hold is counted from the final write, so it overlaps the CS_HOLD wait.
   assign hold_done = (({1'b0, hold_cnt_q} + 17'd1) >= 17'(RST_HOLD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CS_SETUP;
         div_cnt_q  <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         cmd_sr_q   <= '0;
         rx_sr_q    <= '0;
         bit_cnt_q  <= '0;
         mem_we_q   <= 1'b0;
         mem_din_q  <= '0;
         addr_q     <= '0;
         byte_cnt_q <= '0;
         hold_cnt_q <= '0;
         gb_rst_q   <= 1'b1;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         cmd_sr_q   <= cmd_sr_d;
         rx_sr_q    <= rx_sr_d;
         bit_cnt_q  <= bit_cnt_d;
         mem_we_q   <= mem_we_d;
         mem_din_q  <= mem_din_d;
         addr_q     <= addr_d;
         byte_cnt_q <= byte_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         gb_rst_q   <= gb_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CS_SETUP: if (div_tick) state_d = CMD;
         CMD:      if (div_tick && sclk_q && bit_cnt_q == 5'd31) state_d = DATA;
         DATA:     if (last_wr) state_d = CS_HOLD;
         CS_HOLD:  if (div_tick) state_d = RELEASE;
         RELEASE:  if (hold_done) state_d = RUN;
         RUN:      if (start) state_d = CS_SETUP;
         default:  state_d = CS_SETUP;
      endcase
   end

   always_comb begin
      div_cnt_d  = div_tick ? '0 : div_cnt_q + 16'd1;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      cmd_sr_d   = cmd_sr_q;
      rx_sr_d    = rx_sr_q;
      bit_cnt_d  = bit_cnt_q;
      mem_we_d   = 1'b0;
      mem_din_d  = mem_din_q;
      addr_d     = mem_we_q ? addr_q + 16'd1 : addr_q;
      byte_cnt_d = mem_we_q ? byte_cnt_q + BYTE_ONE : byte_cnt_q;
      hold_cnt_d = hold_cnt_q;
      gb_rst_d   = gb_rst_q;
      busy_d     = busy_q;
      done_d     = done_q;
      case (state_q)
         CS_SETUP: begin
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            cmd_sr_d  = CMD_WORD;
            bit_cnt_d = '0;
         end
         CMD: begin
            if (div_tick) begin
               sclk_d = ~sclk_q;
               if (sclk_q) begin
                  cmd_sr_d  = {cmd_sr_q[30:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (last_wr) begin
               sclk_d     = 1'b0;
               cs_n_d     = 1'b1;
               div_cnt_d  = '0;
               hold_cnt_d = 16'd1;
            end else if (div_tick) begin
               sclk_d = ~sclk_q;
               // Sample MISO on the clk that raises SCLK; the flash changes it only on falling edges.
               if (!sclk_q) begin
                  rx_sr_d   = {rx_sr_q[5:0], flash_miso};
                  bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     mem_we_d  = 1'b1;
                     mem_din_d = {rx_sr_q, flash_miso};
                  end
               end
            end
         end
         CS_HOLD: begin
            cs_n_d     = 1'b1;
            sclk_d     = 1'b0;
            hold_cnt_d = hold_cnt_q + 16'd1;
         end
         RELEASE: begin
            hold_cnt_d = hold_cnt_q + 16'd1;
            if (hold_done) begin
               gb_rst_d = hdr_bad;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end
         end
         RUN: begin
            div_cnt_d = '0;
            if (start) begin
               busy_d     = 1'b1;
               done_d     = 1'b0;
               gb_rst_d   = 1'b1;
               addr_d     = '0;
               byte_cnt_d = '0;
               hold_cnt_d = '0;
               bit_cnt_d  = '0;
            end
         end
         default: ;
      endcase
   end

`ifdef CART_LOADER_HDRCHK_EN
   logic [7:0] chk_q, chk_d;
   logic       hdr_err_q, hdr_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q     <= '0;
         hdr_err_q <= 1'b0;
      end else begin
         chk_q     <= chk_d;
         hdr_err_q <= hdr_err_d;
      end
   end

   // Running header checksum over 0x134..0x14C, compared against the byte stored at 0x14D.
   always_comb begin
      chk_d     = chk_q;
      hdr_err_d = hdr_err_q;
      if (state_q == RUN && start) begin
         chk_d     = '0;
         hdr_err_d = 1'b0;
      end else if (mem_we_q) begin
         if (addr_q >= 16'h0134 && addr_q <= 16'h014C) chk_d = chk_q - mem_din_q - 8'd1;
         else if (addr_q == 16'h014D) hdr_err_d = (mem_din_q != chk_q);
      end
   end

   assign hdr_err = hdr_err_q;
   assign hdr_bad = hdr_err_q;
`else
   assign hdr_bad = 1'b0;
`endif

   always_comb begin
      flash_sclk = sclk_q;
      flash_cs_n = cs_n_q;
      flash_mosi = cmd_sr_q[31];
      mem_din    = mem_din_q;
      gb_rst     = gb_rst_q;
      busy       = busy_q;
      done       = done_q;
      if (state_q == RUN) begin
         mem_addr = gb_addr;
         mem_en   = gb_rd;
         mem_we   = 1'b0;
      end else begin
         mem_addr = addr_q;
         mem_en   = mem_we_q;
         mem_we   = mem_we_q;
      end
   end

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: directed bench for cart_loader with a 512-byte image served by a behavioural
// SPI flash holding byte[i] = i ^ 8'h5A.
module tb_cart_loader;

   localparam int ROM_BYTES = 512;
   localparam int SCLK_DIV  = 2;
   localparam int RST_HOLD  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        flash_sclk, flash_cs_n, flash_mosi;
   logic        flash_miso = 1'b0;
   logic [15:0] gb_addr;
   logic        gb_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we, mem_en, gb_rst, busy, done;
`ifdef CART_LOADER_HDRCHK_EN
   logic        hdr_err;
   logic [7:0]  chk;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0]  rom [ROM_BYTES];
   int          fBits = 0;
   int          dBits = 0;
   logic [31:0] cmdWord = '0;

   int         weCount = 0;
   int         nextAddr = 0;
   int         addrErr = 0;
   int         dataErr = 0;
   int         weLongErr = 0;
   int         lastWeCyc = 0;
   int         gbRstFallCyc = 0;
   logic [7:0] din1ff = '0;
   logic       prevWe = 1'b0;
   logic       prevGbRst = 1'b1;

   int   sclkIdleErr = 0;
   int   halfErr = 0;
   int   setupErr = 0;
   int   runLen = 0;
   int   csLowLen = 0;
   bit   seenToggle = 1'b0;
   logic prevSclk = 1'b0;

   cart_loader #(
      .ROM_BYTES (ROM_BYTES),
      .FLASH_BASE(24'h100000),
      .SCLK_DIV  (SCLK_DIV),
      .RST_HOLD  (RST_HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .flash_sclk(flash_sclk),
      .flash_cs_n(flash_cs_n),
      .flash_mosi(flash_mosi),
      .flash_miso(flash_miso),
      .gb_addr   (gb_addr),
      .gb_rd     (gb_rd),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_we    (mem_we),
      .mem_en    (mem_en),
      .gb_rst    (gb_rst),
      .busy      (busy),
      .done      (done)
`ifdef CART_LOADER_HDRCHK_EN
      ,
      .hdr_err   (hdr_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic romBit(input int d);
      int         idx;
      logic [7:0] b;
      idx = (d / 8) % ROM_BYTES;
      b   = rom[idx];
      return b[7 - (d % 8)];
   endfunction

   // Flash model: captures the command on rising SCLK, then presents data bits MSB first.
   always @(negedge flash_cs_n) begin
      fBits      = 0;
      dBits      = 0;
      cmdWord    = '0;
      flash_miso = romBit(0);
   end

   always @(posedge flash_sclk) begin
      if (flash_cs_n === 1'b0) begin
         if (fBits < 32) begin
            cmdWord = {cmdWord[30:0], flash_mosi};
            fBits++;
         end else begin
            dBits++;
         end
         flash_miso = romBit(dBits);
      end
   end

   // Write, reset-release and SCLK timing monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (int'(mem_addr) != nextAddr) addrErr++;
         if (mem_din !== rom[mem_addr[8:0]]) dataErr++;
         if (prevWe === 1'b1) weLongErr++;
         if (mem_addr == 16'h01FF) din1ff = mem_din;
         nextAddr++;
         weCount++;
         lastWeCyc = cyc;
      end
      prevWe = mem_we;
      if (gb_rst === 1'b0 && prevGbRst === 1'b1) gbRstFallCyc = cyc;
      prevGbRst = gb_rst;

      if (rst_n !== 1'b1 || flash_cs_n === 1'b1) begin
         if (flash_cs_n === 1'b1 && flash_sclk !== 1'b0) sclkIdleErr++;
         seenToggle = 1'b0;
         csLowLen   = 0;
         runLen     = 0;
      end else begin
         if (flash_sclk !== prevSclk) begin
            if (seenToggle && runLen != SCLK_DIV) halfErr++;
            if (!seenToggle && csLowLen < SCLK_DIV) setupErr++;
            seenToggle = 1'b1;
            runLen     = 1;
         end else begin
            runLen++;
         end
         csLowLen++;
      end
      prevSclk = flash_sclk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [15:0] a, input logic r);
      @(negedge clk);
      start   = s;
      gb_addr = a;
      gb_rd   = r;
   endtask

   task automatic clearCounters();
      weCount      = 0;
      nextAddr     = 0;
      gbRstFallCyc = 0;
      din1ff       = '0;
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("doneReached", {31'd0, done}, 32'd1);
      @(negedge clk);
   endtask

   task automatic waitWrites(input int target, input int budget);
      int n = 0;
      while (weCount < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("writesReached", (weCount >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_cs_n"}, {31'd0, flash_cs_n}, 32'd1);
      checkOutput({tag, "_sclk"}, {31'd0, flash_sclk}, 32'd0);
      checkOutput({tag, "_mosi"}, {31'd0, flash_mosi}, 32'd0);
      checkOutput({tag, "_we"}, {31'd0, mem_we}, 32'd0);
      checkOutput({tag, "_en"}, {31'd0, mem_en}, 32'd0);
      checkOutput({tag, "_din"}, {24'd0, mem_din}, 32'd0);
      checkOutput({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
      checkOutput({tag, "_gbrst"}, {31'd0, gb_rst}, 32'd1);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   task automatic checkLoad(input string tag);
      checkOutput({tag, "_cmd"}, cmdWord, 32'h03100000);
      checkOutput({tag, "_writes"}, weCount, 32'd512);
      checkOutput({tag, "_addrSeq"}, addrErr, 32'd0);
      checkOutput({tag, "_data"}, dataErr, 32'd0);
      checkOutput({tag, "_din1ff"}, {24'd0, din1ff}, 32'h000000A5);
      checkOutput({tag, "_weWidth"}, weLongErr, 32'd0);
      checkOutput({tag, "_rstDelay"}, gbRstFallCyc - lastWeCyc, 32'd16);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_gbrst"}, {31'd0, gb_rst}, 32'd0);
      checkOutput({tag, "_sclkIdle"}, sclkIdleErr, 32'd0);
      checkOutput({tag, "_sclkHalf"}, halfErr, 32'd0);
      checkOutput({tag, "_csSetup"}, setupErr, 32'd0);
`ifdef CART_LOADER_HDRCHK_EN
      checkOutput({tag, "_hdrErr"}, {31'd0, hdr_err}, 32'd0);
`endif
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      gb_addr = '0;
      gb_rd   = 1'b0;
      for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'(i) ^ 8'h5A;
`ifdef CART_LOADER_HDRCHK_EN
      chk = 8'd0;
      for (int i = 'h134; i <= 'h14C; i++) chk = chk - rom[i] - 8'd1;
      rom['h14D] = chk;
`endif

      repeat (3) @(negedge clk);
      checkResetState("reset");

      // First load with a start pulse in the middle that must be ignored.
      clearCounters();
      rst_n = 1'b1;
      waitWrites(50, 5000);
      applyStimulus(1'b1, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      checkOutput("midStartBusy", {31'd0, busy}, 32'd1);
      waitDone(20000);
      checkLoad("load1");

      // Core owns the RAM port in RUN.
      applyStimulus(1'b0, 16'h0150, 1'b1);
      #1;
      checkOutput("runAddr", {16'd0, mem_addr}, 32'h00000150);
      checkOutput("runEn", {31'd0, mem_en}, 32'd1);
      checkOutput("runWe", {31'd0, mem_we}, 32'd0);
      applyStimulus(1'b0, 16'h1234, 1'b0);
      #1;
      checkOutput("runAddr2", {16'd0, mem_addr}, 32'h00001234);
      checkOutput("runEnIdle", {31'd0, mem_en}, 32'd0);

      // Reload from RUN; the core bus must be ignored while busy.
      clearCounters();
      applyStimulus(1'b1, 16'h0150, 1'b1);
      applyStimulus(1'b0, 16'h0150, 1'b1);
      checkOutput("reloadGbRst", {31'd0, gb_rst}, 32'd1);
      checkOutput("reloadBusy", {31'd0, busy}, 32'd1);
      checkOutput("reloadDone", {31'd0, done}, 32'd0);
      checkOutput("busyAddr", {16'd0, mem_addr}, 32'd0);
      checkOutput("busyEn", {31'd0, mem_en}, 32'd0);
      waitDone(20000);
      checkLoad("reload");

      // Asynchronous reset after byte 100 of a further load.
      clearCounters();
      applyStimulus(1'b1, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      waitWrites(101, 6000);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("midReset");
      repeat (3) @(negedge clk);
      clearCounters();
      rst_n = 1'b1;
      waitDone(20000);
      checkLoad("afterReset");

`ifdef CART_LOADER_HDRCHK_EN
      // Corrupt a header byte: done still asserts but the core stays in reset.
      rom['h140] = rom['h140] ^ 8'h01;
      clearCounters();
      applyStimulus(1'b1, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      waitDone(20000);
      checkOutput("badHdr_err", {31'd0, hdr_err}, 32'd1);
      checkOutput("badHdr_gbrst", {31'd0, gb_rst}, 32'd1);
      checkOutput("badHdr_done", {31'd0, done}, 32'd1);
      checkOutput("badHdr_writes", weCount, 32'd512);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
